// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_seq_pkg: shared branch funct3 codes and sequencer state type
// Rev 1.0
// ----------------------------------------------------------------------------
package pc_seq_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2
  } pcseq_state_t;

endpackage
`default_nettype wire

// File: rtl/br_cond_eval.sv
`default_nettype none
// ----------------------------------------------------------------------------
// br_cond_eval: decodes branch funct3 against comparator flags into taken/illegal
// Rev 1.0
// ----------------------------------------------------------------------------
module br_cond_eval
  import pc_seq_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_more,
  input  logic       cmp_even,
  input  logic       cmp_less,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:            taken = cmp_even;
      F3_BNE:            taken = ~cmp_even;
      F3_BLT, F3_BLTU:   taken = cmp_less;
      F3_BGE, F3_BGEU:   taken = cmp_more | cmp_even;
      default:           illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_sequencer: owns the fetch PC, drives imem req/ack, turns branches/jumps into redirects
// Rev 1.0
// ----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  input  logic             cmp_more,
  input  logic             cmp_even,
  input  logic             cmp_less,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  output logic             flush,
  output logic             redirect,
  output logic             err_misalign,
  output logic             err_funct3,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  pcseq_state_t     state;
  logic [31:0]      pc;
  logic [3:0]       flush_cnt;
  logic [CNT_W-1:0] taken_cnt_q;

  logic        br_taken;
  logic        br_illegal;
  logic        want_redirect;
  logic [31:0] target;

  br_cond_eval u_cond (
    .funct3   (br_funct3),
    .cmp_more (cmp_more),
    .cmp_even (cmp_even),
    .cmp_less (cmp_less),
    .taken    (br_taken),
    .illegal  (br_illegal)
  );

  // A branch is always older than a concurrent jump, so it alone decides.
  always_comb begin
    if (br_valid) begin
      want_redirect = br_taken;
      target        = br_pc + br_imm;
    end else begin
      want_redirect = jmp_valid;
      target        = jmp_target & 32'hFFFF_FFFE;
    end
  end

  assign br_ready     = (state == S_REQ);
  assign imem_req     = br_ready & ~stall;
  assign imem_addr    = pc;
  assign flush        = (state == S_FLUSH);
  assign redirect     = br_ready & want_redirect & ~target[1];
  assign err_misalign = br_ready & want_redirect & target[1];
  assign err_funct3   = br_ready & br_valid & br_illegal;
  assign taken_cnt    = taken_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      flush_cnt   <= 4'd0;
      taken_cnt_q <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          // Redirect beats both stall and a same-cycle ack; the acked fetch is squashed.
          if (redirect) begin
            pc        <= target;
            flush_cnt <= FLUSH_LOAD;
            state     <= S_FLUSH;
            if (taken_cnt_q != {CNT_W{1'b1}}) begin
              taken_cnt_q <= taken_cnt_q + 1'b1;
            end
          end else if (imem_ack && !stall) begin
            pc <= pc + 32'd4;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= S_REQ;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pc_sequencer: directed, table-driven and randomized checks against a cycle model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;
  localparam int          CNT_W        = 4;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, stall, imem_ack, br_valid, cmp_more, cmp_even, cmp_less, jmp_valid;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc, br_imm, jmp_target;
  logic imem_req, br_ready, flush, redirect, err_misalign, err_funct3;
  logic [31:0] imem_addr;
  logic [CNT_W-1:0] taken_cnt;

  pc_sequencer #(
    .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
    .br_pc(br_pc), .br_imm(br_imm), .cmp_more(cmp_more), .cmp_even(cmp_even),
    .cmp_less(cmp_less), .jmp_valid(jmp_valid), .jmp_target(jmp_target), .flush(flush),
    .redirect(redirect), .err_misalign(err_misalign), .err_funct3(err_funct3),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: boot pending, remaining flush cycles, pc, taken count.
  bit          m_boot;
  int          m_flush_left;
  logic [31:0] m_pc;
  int          m_cnt;

  logic        last_req, last_flush, last_redirect, last_mis, last_errf;
  logic [31:0] last_addr;
  logic [CNT_W-1:0] last_cnt;

  typedef struct {
    logic [2:0]  f3;
    logic        more, even, less;
    logic [31:0] bpc, imm;
    logic        exp_redir, exp_f3err, exp_mis;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_flush_left = 0;
    m_pc = RESET_PC;
    m_cnt = 0;
  endtask

  task automatic clear_inputs();
    stall = 0; imem_ack = 0; br_valid = 0; cmp_more = 0; cmp_even = 0; cmp_less = 0;
    jmp_valid = 0; br_funct3 = 3'b000; br_pc = 0; br_imm = 0; jmp_target = 0;
  endtask

  // Called just after a rising edge with inputs set; compares, advances the model, crosses an edge.
  task automatic step();
    logic ready, want, tk, ill, mis, redir, errf;
    logic [31:0] tgt;
    logic [CNT_W-1:0] mc;
    logic [63:0] exp_v, act_v;
    #1;
    ready = !m_boot && (m_flush_left == 0);
    tk = 1'b0; ill = 1'b0;
    case (br_funct3)
      3'd0:       tk = cmp_even;
      3'd1:       tk = !cmp_even;
      3'd4, 3'd6: tk = cmp_less;
      3'd5, 3'd7: tk = cmp_more || cmp_even;
      default:    ill = 1'b1;
    endcase
    if (br_valid) begin
      want = tk;
      tgt = br_pc + br_imm;
    end else begin
      want = jmp_valid;
      tgt = jmp_target - (jmp_target % 2);
    end
    mis   = ready && want && tgt[1];
    redir = ready && want && !tgt[1];
    errf  = ready && br_valid && ill;
    mc = m_cnt[CNT_W-1:0];
    exp_v = {22'd0, ready && !stall, m_pc, ready, m_flush_left > 0, redir, mis, errf, mc};
    act_v = {22'd0, imem_req, imem_addr, br_ready, flush, redirect, err_misalign, err_funct3, taken_cnt};
    chk("cycle_outputs", act_v, exp_v);
    last_req = imem_req; last_addr = imem_addr; last_flush = flush; last_redirect = redirect;
    last_mis = err_misalign; last_errf = err_funct3; last_cnt = taken_cnt;
    if (!rst_n) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (redir) begin
      m_pc = tgt;
      m_flush_left = FLUSH_CYCLES;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (imem_ack && !stall) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'b000, 0, 1, 0, 32'h100, 32'h10, 1, 0, 0};
    tbl[1]  = '{3'b000, 1, 0, 0, 32'h100, 32'h10, 0, 0, 0};
    tbl[2]  = '{3'b001, 0, 1, 0, 32'h100, 32'h10, 0, 0, 0};
    tbl[3]  = '{3'b001, 0, 0, 1, 32'h100, 32'h10, 1, 0, 0};
    tbl[4]  = '{3'b100, 0, 0, 1, 32'h100, 32'h10, 1, 0, 0};
    tbl[5]  = '{3'b110, 1, 0, 0, 32'h100, 32'h10, 0, 0, 0};
    tbl[6]  = '{3'b101, 0, 1, 0, 32'h100, 32'h10, 1, 0, 0};
    tbl[7]  = '{3'b111, 1, 0, 0, 32'h100, 32'h10, 1, 0, 0};
    tbl[8]  = '{3'b101, 0, 0, 1, 32'h100, 32'h10, 0, 0, 0};
    tbl[9]  = '{3'b010, 0, 1, 0, 32'h100, 32'h10, 0, 1, 0};
    tbl[10] = '{3'b011, 1, 0, 1, 32'h100, 32'h10, 0, 1, 0};
    tbl[11] = '{3'b000, 0, 1, 0, 32'h100, 32'h2,  0, 0, 1};
    tbl[12] = '{3'b001, 0, 0, 0, 32'h100, 32'h6,  0, 0, 1};
    tbl[13] = '{3'b000, 0, 0, 0, 32'h100, 32'h2,  0, 0, 0};

    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();

    // Boot then sequential fetch 0x0, 0x4, 0x8.
    rst_n = 1'b1; imem_ack = 1'b1;
    step(); chk("boot_req", {63'd0, last_req}, 64'd0);
    step(); chk("seq_addr0", {32'd0, last_addr}, 64'h0); chk("seq_req0", {63'd0, last_req}, 64'd1);
    step(); chk("seq_addr4", {32'd0, last_addr}, 64'h4);
    step(); chk("seq_addr8", {32'd0, last_addr}, 64'h8);

    // BEQ taken to 0x100 + (-16) = 0xF0.
    br_valid = 1; br_funct3 = 3'b000; cmp_even = 1; br_pc = 32'h100; br_imm = 32'hFFFF_FFF0;
    step(); chk("beq_redirect", {63'd0, last_redirect}, 64'd1);
    br_valid = 0; cmp_even = 0;
    step(); chk("beq_flush1", {63'd0, last_flush}, 64'd1);
    step(); chk("beq_flush2", {63'd0, last_flush}, 64'd1);
    step(); chk("beq_resume_flush", {63'd0, last_flush}, 64'd0);
    chk("beq_resume_addr", {32'd0, last_addr}, 64'hF0);

    // BNE with equal operands: not taken.
    br_valid = 1; br_funct3 = 3'b001; cmp_even = 1;
    step(); chk("bne_no_redirect", {63'd0, last_redirect}, 64'd0);
    chk("bne_cnt", {60'd0, last_cnt}, 64'd1);
    br_valid = 0; cmp_even = 0;
    step(); chk("bne_seq_addr", {32'd0, last_addr}, 64'hF8);

    // Branch, jump and ack together: branch wins, ack squashed.
    br_valid = 1; br_funct3 = 3'b100; cmp_less = 1; br_pc = 32'h200; br_imm = 0;
    jmp_valid = 1; jmp_target = 32'h400;
    step(); chk("prio_redirect", {63'd0, last_redirect}, 64'd1);
    br_valid = 0; cmp_less = 0; jmp_valid = 0;
    step(); step();
    step(); chk("prio_target", {32'd0, last_addr}, 64'h200);
    step(); chk("prio_next", {32'd0, last_addr}, 64'h204);

    // Misaligned taken target 0x102.
    br_valid = 1; br_funct3 = 3'b000; cmp_even = 1; br_pc = 32'h100; br_imm = 32'h2;
    step(); chk("mis_pulse", {62'd0, last_mis, last_redirect}, 64'b10);
    br_valid = 0; cmp_even = 0;
    step(); chk("mis_no_flush", {63'd0, last_flush}, 64'd0);
    chk("mis_seq_addr", {32'd0, last_addr}, 64'h20C);

    // Reset in the middle of a flush window.
    jmp_valid = 1; jmp_target = 32'hFFFF_FFFD;
    step(); chk("jmp_redirect", {63'd0, last_redirect}, 64'd1);
    jmp_valid = 0;
    step(); chk("jmp_flush", {63'd0, last_flush}, 64'd1);
    rst_n = 0;
    step();
    rst_n = 1;
    step(); chk("rst_flush", {63'd0, last_flush}, 64'd0);
    chk("rst_addr", {32'd0, last_addr}, {32'd0, RESET_PC});

    // PC wrap from 0xFFFF_FFFC.
    jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
    step(); jmp_valid = 0;
    step(); step();
    step(); chk("wrap_top", {32'd0, last_addr}, 64'hFFFF_FFFC);
    step(); chk("wrap_zero", {32'd0, last_addr}, 64'h0);

    // Condition table, each vector applied from a ready state.
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      for (int k = 0; k < 10 && (m_boot || m_flush_left != 0); k++) step();
      br_valid = 1; br_funct3 = tbl[i].f3; cmp_more = tbl[i].more; cmp_even = tbl[i].even;
      cmp_less = tbl[i].less; br_pc = tbl[i].bpc; br_imm = tbl[i].imm;
      step();
      chk($sformatf("tbl%0d", i), {61'd0, last_redirect, last_errf, last_mis},
          {61'd0, tbl[i].exp_redir, tbl[i].exp_f3err, tbl[i].exp_mis});
    end
    clear_inputs();

    // Randomized traffic against the model; counter saturates at CNT_W bits.
    for (int n = 0; n < 1500; n++) begin
      rst_n      = ($urandom % 120) != 0;
      stall      = ($urandom % 4) == 0;
      imem_ack   = $urandom % 2;
      br_valid   = ($urandom % 4) == 0;
      br_funct3  = 3'($urandom % 8);
      cmp_more   = $urandom % 2;
      cmp_even   = $urandom % 2;
      cmp_less   = $urandom % 2;
      br_pc      = $urandom & 32'hFFFF_FFFC;
      br_imm     = $urandom & 32'hFFFF_FFFE;
      jmp_valid  = ($urandom % 5) == 0;
      jmp_target = $urandom;
      step();
    end
    chk("final_cnt_model", {60'd0, taken_cnt}, {32'd0, m_cnt});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
